// File: rtl/fetch_unit.sv
// IF stage of the 5-stage RV32I pipeline: owns the PC, runs a single-outstanding imem
// request/ack handshake and fills IF/ID. Optional feature macro: FETCH_MISALIGN_CHECK_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hazard_stall,
    input  logic        data_mem_wait,
    input  logic        flush_if_id,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_mem_wait,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc,
    output logic        if_id_valid,
    output logic        if_id_misaligned
);

    localparam logic [1:0] S_REQ     = 2'd0;
    localparam logic [1:0] S_DISCARD = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;
`ifdef FETCH_MISALIGN_CHECK_EN
    localparam logic [1:0]  S_HALT  = 2'd3;
    localparam logic [31:0] PC_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;
`endif

    logic [1:0]  state, state_d;
    logic [31:0] pc, pc_d;
    logic [31:0] pend_pc, pend_pc_d;
    logic [31:0] hold_inst, hold_inst_d;
    logic [31:0] hold_pc, hold_pc_d;
    logic [31:0] if_id_inst_d, if_id_pc_d;
    logic        if_id_valid_d, if_id_mis_d;
    logic        stall_if;
    logic        do_jump;
    logic [31:0] jump_target;
    logic [31:0] redirect_target;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        marker_pending, marker_d;
`endif

    assign stall_if        = hazard_stall | data_mem_wait;
    assign redirect_target = redirect_pc & PC_MASK;
    assign imem_addr       = pc;

    // Deliberately independent of stall_if so there is no loop through the hazard unit.
    always_comb begin
        imem_req      = 1'b0;
        inst_mem_wait = 1'b0;
        if (!rst) begin
            case (state)
                S_REQ: begin
                    imem_req      = 1'b1;
                    inst_mem_wait = !imem_ack;
                end
                S_DISCARD: begin
                    imem_req      = 1'b1;
                    inst_mem_wait = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        // NOTE: every next-state variable gets a default first so no branch can infer a latch.
        state_d       = state;
        pc_d          = pc;
        pend_pc_d     = pend_pc;
        hold_inst_d   = hold_inst;
        hold_pc_d     = hold_pc;
        if_id_inst_d  = if_id_inst;
        if_id_pc_d    = if_id_pc;
        if_id_valid_d = if_id_valid;
        if_id_mis_d   = if_id_misaligned;
        do_jump       = 1'b0;
        jump_target   = redirect_target;
`ifdef FETCH_MISALIGN_CHECK_EN
        marker_d      = marker_pending;
`endif

        if (flush_if_id) begin
            if_id_valid_d = 1'b0;
            if_id_inst_d  = NOP_INST;
            if_id_mis_d   = 1'b0;
        end

        case (state)
            S_REQ: begin
                if (imem_ack && redirect_valid) begin
                    if_id_valid_d = 1'b0;
                    if_id_mis_d   = 1'b0;
                    do_jump       = 1'b1;
                end else if (imem_ack && stall_if) begin
                    hold_inst_d = imem_rdata;
                    hold_pc_d   = pc;
                    pc_d        = pc + 32'd4;
                    state_d     = S_HOLD;
                end else if (imem_ack) begin
                    if_id_inst_d  = imem_rdata;
                    if_id_pc_d    = pc;
                    if_id_valid_d = !flush_if_id;
                    if_id_mis_d   = 1'b0;
                    pc_d          = pc + 32'd4;
                end else if (redirect_valid) begin
                    // The in-flight request keeps its address; the target waits in pend_pc.
                    if_id_valid_d = 1'b0;
                    if_id_mis_d   = 1'b0;
                    pend_pc_d     = redirect_target;
                    state_d       = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (redirect_valid) begin
                    if_id_valid_d = 1'b0;
                    if_id_mis_d   = 1'b0;
                    pend_pc_d     = redirect_target;
                end
                if (imem_ack) begin
                    do_jump     = 1'b1;
                    jump_target = redirect_valid ? redirect_target : pend_pc;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    if_id_valid_d = 1'b0;
                    if_id_mis_d   = 1'b0;
                    do_jump       = 1'b1;
                end else if (!stall_if) begin
                    if_id_inst_d  = hold_inst;
                    if_id_pc_d    = hold_pc;
                    if_id_valid_d = !flush_if_id;
                    if_id_mis_d   = 1'b0;
                    state_d       = S_REQ;
                end
            end
`ifdef FETCH_MISALIGN_CHECK_EN
            S_HALT: begin
                if (redirect_valid) begin
                    if_id_valid_d = 1'b0;
                    if_id_mis_d   = 1'b0;
                    do_jump       = 1'b1;
                end else if (marker_pending && !stall_if) begin
                    if_id_inst_d  = NOP_INST;
                    if_id_pc_d    = pc;
                    if_id_valid_d = !flush_if_id;
                    if_id_mis_d   = !flush_if_id;
                    marker_d      = 1'b0;
                end
            end
`endif
            default: state_d = S_REQ;
        endcase

        if (do_jump) begin
            pc_d    = jump_target;
            state_d = S_REQ;
`ifdef FETCH_MISALIGN_CHECK_EN
            // A misaligned target never reaches memory; it becomes a marker entry instead.
            marker_d = |jump_target[1:0];
            if (marker_d) state_d = S_HALT;
`endif
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state            <= S_REQ;
            pc               <= RESET_PC & PC_MASK;
            pend_pc          <= 32'd0;
            hold_inst        <= 32'd0;
            hold_pc          <= 32'd0;
            if_id_inst       <= NOP_INST;
            if_id_pc         <= 32'd0;
            if_id_valid      <= 1'b0;
            if_id_misaligned <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
            marker_pending   <= 1'b0;
`endif
        end else begin
            state            <= state_d;
            pc               <= pc_d;
            pend_pc          <= pend_pc_d;
            hold_inst        <= hold_inst_d;
            hold_pc          <= hold_pc_d;
            if_id_inst       <= if_id_inst_d;
            if_id_pc         <= if_id_pc_d;
            if_id_valid      <= if_id_valid_d;
            if_id_misaligned <= if_id_mis_d;
`ifdef FETCH_MISALIGN_CHECK_EN
            marker_pending   <= marker_d;
`endif
        end
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- IF stage of the 5-stage RV32I pipeline; directly upstream of the hazard/stall control logic and the ID stage.
- Owns the PC and runs a single-outstanding request/ack handshake to instruction memory.
- Fills the IF/ID register (inst, pc, valid) and produces inst_mem_wait for the hazard unit.
- Consumes hazard_stall, data_mem_wait, the IF/ID flush bit and the redirect (branch/JAL/JALR) target.

Parameters:
RESET_PC, 32'h8000_0000, first fetch address after reset
NOP_INST, 32'h0000_0013, value loaded into if_id_inst on reset and on flush (addi x0,x0,0)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
hazard_stall  in  1  hold IF/ID and PC (load-use / branch hazards)
data_mem_wait  in  1  data memory busy; freezes IF/ID and PC
flush_if_id  in  1  flush_mask[0] from hazard unit; invalidate IF/ID
redirect_valid  in  1  one-cycle pulse: redirect PC to redirect_pc
redirect_pc  in  32  redirect target
imem_req  out  1  instruction fetch request
imem_addr  out  32  fetch address, word aligned
imem_ack  in  1  fetch complete; imem_rdata valid this cycle
imem_rdata  in  32  fetched instruction
inst_mem_wait  out  1  fetch not ready; pipeline must freeze
if_id_inst  out  32  IF/ID instruction
if_id_pc  out  32  IF/ID PC
if_id_valid  out  1  IF/ID holds a live instruction
if_id_misaligned  out  1  IF/ID entry is a misaligned-fetch marker (feature only)

Behaviour:
- Stall definition: stall_if = hazard_stall | data_mem_wait.
- inst_mem_wait is a combinational function of state and imem_ack only. It never depends on stall_if, so no loop exists through mem_stall.
- Reset (synchronous, priority over all other inputs):
  - pc=RESET_PC; state=S_REQ.
  - if_id_valid=0; if_id_inst=NOP_INST; if_id_pc=0; if_id_misaligned=0.
  - hold buffer empty.
  - While rst is high: imem_req=0 and inst_mem_wait=0.
- Handshake rules:
  - In S_REQ, imem_req=1 and imem_addr=pc.
  - imem_addr stays stable until imem_ack is sampled high.
  - imem_ack may arrive in the first request cycle (0-wait memory).
  - At most one request is outstanding. Acks seen outside S_REQ/S_DISCARD are ignored.
- S_REQ:
  - ack & redirect_valid: discard rdata; pc<=redirect_pc; if_id_valid<=0; stay in S_REQ.
  - ack & !redirect & stall_if:
    - Store rdata and pc in the hold buffer; pc<=pc+4; go to S_HOLD.
    - IF/ID keeps its current value, or takes a bubble (valid=0) if flush_if_id.
  - ack & no redirect & !stall_if:
    - if_id_inst<=rdata; if_id_pc<=pc; if_id_valid<=!flush_if_id; pc<=pc+4.
    - Back-to-back throughput is 1 instruction/cycle with a 0-wait memory.
  - !ack: inst_mem_wait=1.
    - If redirect_valid: latch redirect_pc into pend_pc, set if_id_valid<=0, go to S_DISCARD.
    - imem_addr is not changed mid-request.
- S_DISCARD:
  - imem_req=1 with the old address; inst_mem_wait=1.
  - On ack: drop rdata; pc<=pend_pc; go to S_REQ.
  - A further redirect_valid overwrites pend_pc.
- S_HOLD:
  - imem_req=0; inst_mem_wait=0.
  - redirect_valid: drop the buffer; pc<=redirect_pc; if_id_valid<=0; go to S_REQ.
  - Else if !stall_if: IF/ID<=buffer (valid=!flush_if_id); go to S_REQ.
- flush_if_id without redirect_valid only clears if_id_valid (inst<=NOP_INST). The PC is unaffected.
- Otherwise, while stall_if=1 the IF/ID outputs hold their values.
- redirect_valid is honoured regardless of stall_if. Redirect has priority over stall, over buffered data and over in-flight data.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0. No fault is raised.
- Without the feature, imem_addr[1:0] and all stored PCs have bits [1:0] forced to 2'b00.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- With the macro:
  - A redirect_pc with [1:0]!=0 issues no memory request.
  - Next non-stalled cycle: if_id_inst=NOP_INST, if_id_pc=redirect_pc (unmasked), if_id_valid=1, if_id_misaligned=1.
  - The block then enters S_HALT: imem_req=0, inst_mem_wait=0.
  - S_HALT exits only on the next redirect_valid.
- Without the macro: S_HALT does not exist, if_id_misaligned is tied 0, and the low PC bits are masked.

Test Plan:
- Reset: rst high 2 cycles then low, 0-wait memory → imem_addr 8000_0000, 8000_0004, 8000_0008 on consecutive cycles; if_id_valid rises 1 cycle after the first ack.
- 3-cycle memory latency: ack on the 3rd request cycle → inst_mem_wait=1 for 2 cycles, imem_addr stable at 8000_0000, IF/ID updated once.
- Redirect mid-request: redirect_pc=8000_0100 pulse while waiting for 8000_0004 → state S_DISCARD; stale rdata not in IF/ID; next request address is 8000_0100.
- hazard_stall for 2 cycles coincident with ack of 8000_0008:
  - IF/ID holds the 8000_0004 instruction; no request is issued during the stall.
  - After the stall, IF/ID shows pc 8000_0008 and the next request is 8000_000C.
- flush_if_id with redirect_valid in S_HOLD → buffer dropped; if_id_valid=0, if_id_inst=0000_0013; next fetch is at redirect_pc.
- FETCH_MISALIGN_CHECK_EN, redirect_pc=8000_0102 → no imem_req; if_id_misaligned=1, if_id_pc=8000_0102; stays idle until redirect_pc=8000_0200.
